// File: rtl/jogador_automatico.sv
// Automatic player for the memory game: records the LED sequence the game
// displays and replays it as timed button presses when a play is awaited.
module jogador_automatico #(
  parameter int PROFUNDIDADE = 16,
  parameter int GAP_CICLOS   = 4,
  parameter int HOLD_CICLOS  = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [3:0] leds,
  input  logic       liga_led,
  input  logic       esperando_jogada,
  output logic [3:0] botoes,
  output logic       pressionando,
  output logic       concluido,
  output logic       overflow,
  output logic [3:0] db_estado
);

  localparam int AW   = $clog2(PROFUNDIDADE);
  localparam int CW   = AW + 1;
  localparam int MAXC = (GAP_CICLOS > HOLD_CICLOS) ? GAP_CICLOS : HOLD_CICLOS;
  localparam int TW   = $clog2(MAXC) + 1;

  localparam logic [TW-1:0] GAP_FIM  = TW'(GAP_CICLOS - 1);
  localparam logic [TW-1:0] HOLD_FIM = TW'(HOLD_CICLOS - 1);
  localparam logic [CW-1:0] CAP_MAX  = CW'(PROFUNDIDADE);

  typedef enum logic [3:0] {
    OCIOSO    = 4'd0,
    CAPTURA   = 4'd1,
    GAP       = 4'd2,
    PRESSIONA = 4'd3,
    SOLTA     = 4'd4,
    FIM       = 4'd5
  } estado_t;

  estado_t       estado, estado_prox;
  logic [CW-1:0] count, count_prox;
  logic [AW-1:0] rd, rd_prox;
  logic [TW-1:0] timer, timer_prox;
  logic          overflow_prox;
  logic          liga_led_d;
  logic          cap;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    mem [PROFUNDIDADE];

  // A capture is a rising edge of the display strobe showing a non-blank pattern.
  assign cap = liga_led & ~liga_led_d & (leds != 4'b0000);

  always_comb begin
    estado_prox   = estado;
    count_prox    = count;
    rd_prox       = rd;
    timer_prox    = timer;
    overflow_prox = overflow;
    wr_en         = 1'b0;
    wr_addr       = count[AW-1:0];

    if (!habilita) begin
      estado_prox = OCIOSO;
      timer_prox  = '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (cap) begin
            wr_en         = 1'b1;
            wr_addr       = '0;
            count_prox    = CW'(1);
            rd_prox       = '0;
            overflow_prox = 1'b0;
            estado_prox   = CAPTURA;
          end
        end
        CAPTURA: begin
          if (esperando_jogada) begin
            estado_prox = GAP;
            timer_prox  = '0;
          end else if (cap) begin
            if (count < CAP_MAX) begin
              wr_en      = 1'b1;
              count_prox = count + CW'(1);
            end else begin
              overflow_prox = 1'b1;
            end
          end
        end
        GAP: begin
          // Timer saturates so a stalled game resumes with a single-cycle wait.
          if (timer == GAP_FIM) begin
            if (esperando_jogada) begin
              estado_prox = PRESSIONA;
              timer_prox  = '0;
            end
          end else begin
            timer_prox = timer + TW'(1);
          end
        end
        PRESSIONA: begin
          if (timer == HOLD_FIM) begin
            estado_prox = SOLTA;
            timer_prox  = '0;
          end else begin
            timer_prox = timer + TW'(1);
          end
        end
        SOLTA: begin
          // rd only advances when more entries remain, so it never wraps.
          if (({1'b0, rd} + CW'(1)) == count) begin
            estado_prox = FIM;
          end else begin
            rd_prox     = rd + AW'(1);
            estado_prox = GAP;
            timer_prox  = '0;
          end
        end
        FIM: begin
          estado_prox = OCIOSO;
        end
        default: begin
          estado_prox = OCIOSO;
          timer_prox  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= OCIOSO;
      count      <= '0;
      rd         <= '0;
      timer      <= '0;
      overflow   <= 1'b0;
      liga_led_d <= 1'b0;
    end else begin
      estado     <= estado_prox;
      count      <= count_prox;
      rd         <= rd_prox;
      timer      <= timer_prox;
      overflow   <= overflow_prox;
      liga_led_d <= liga_led;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en && !reset) begin
      mem[wr_addr] <= leds;
    end
  end

  always_comb begin
    botoes = 4'b0000;
    if (estado == PRESSIONA) begin
      botoes = mem[rd];
    end
  end

  assign pressionando = (estado == PRESSIONA);
  assign concluido    = (estado == FIM);
  assign db_estado    = estado;

endmodule
